// File: rtl/facto_host_pkg.sv
// ---------------------------------------------------------------------------
// facto_host_pkg
// Purpose : shared definitions for the factorial-core host sequencer.
//           Holds the FSM state encoding, the register offsets of the
//           factorial core (relative to the FACTO_BASE module parameter),
//           and the packed bus-output bundle registered by the FSM.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package facto_host_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        REQ      = 4'd1,
        W_INTEN  = 4'd2,
        W_OPND   = 4'd3,
        W_START  = 4'd4,
        WAIT_INT = 4'd5,
        R_HI     = 4'd6,
        R_LO     = 4'd7,
        CAP_LO   = 4'd8,
        W_CLR1   = 4'd9,
        W_CLR0   = 4'd10,
        RELEASE  = 4'd11
    } state_t;

    // Register offsets inside the factorial core block.
    localparam logic [15:0] OFF_OPSTART  = 16'h0000;
    localparam logic [15:0] OFF_OPCLEAR  = 16'h0008;
    localparam logic [15:0] OFF_OPDONE   = 16'h0010;
    localparam logic [15:0] OFF_INTR_EN  = 16'h0018;
    localparam logic [15:0] OFF_OPERAND  = 16'h0020;
    localparam logic [15:0] OFF_RESULT_H = 16'h0028;
    localparam logic [15:0] OFF_RESULT_L = 16'h0030;

    // Everything the master drives onto the bus, registered as one bundle.
    typedef struct packed {
        logic        req;
        logic        wr;
        logic [15:0] addr;
        logic [63:0] dout;
    } bus_t;

endpackage

// File: rtl/facto_host.sv
// ---------------------------------------------------------------------------
// facto_host
// Purpose : bus master that drives a memory-mapped factorial core. On an
//           accepted start it takes the bus, enables the core interrupt,
//           writes the operand, kicks the core, waits for its interrupt
//           (bounded by TIMEOUT), reads the 128-bit result, clears the core
//           and releases the bus with a one-cycle done pulse.
//
// Ports   : clk, reset        clock, synchronous active-high reset
//           start, operand    request (ignored while busy) and its value
//           m_req/m_grant     bus request / grant
//           m_wr, m_addr,     write strobe, address and write data
//           m_dout
//           m_din             read data, returned one cycle after the read
//           interrupt         level interrupt from the core
//           busy, done,       status; error flags a timeout abort
//           error
//           result            {result_h, result_l}, held between runs
//           dbg_state         current FSM state for observation
//
// Bus handshake: a transaction completes on every rising edge where
// m_req=1 and m_grant=1. While m_grant=0 the FSM holds its state and every
// output unchanged, so the same transaction is simply re-presented. Read
// data for an accepted read appears on m_din in the following cycle.
// All outputs are registered; when m_req=0, m_wr/m_addr/m_dout are 0.
// ---------------------------------------------------------------------------
module facto_host
    import facto_host_pkg::*;
#(
    parameter logic [15:0] FACTO_BASE = 16'h7000,
    parameter logic [15:0] TIMEOUT    = 16'd4095
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [63:0]   operand,
    input  logic          m_grant,
    input  logic [63:0]   m_din,
    input  logic          interrupt,
    output logic          m_req,
    output logic          m_wr,
    output logic [15:0]   m_addr,
    output logic [63:0]   m_dout,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [127:0]  result,
    output state_t        dbg_state
);

    state_t      state;
    state_t      state_nxt;
    bus_t        bus_q;
    logic [63:0] operand_q;
    logic [15:0] wait_cnt;
    logic        timeout_hit;

    assign m_req     = bus_q.req;
    assign m_wr      = bus_q.wr;
    assign m_addr    = bus_q.addr;
    assign m_dout    = bus_q.dout;
    assign dbg_state = state;

    // Widened compare so TIMEOUT=0 cannot wrap.
    assign timeout_hit = ({1'b0, wait_cnt} + 17'd1) >= {1'b0, TIMEOUT};

    // Bus outputs that belong to a given state. Registering the value for
    // the next state keeps every output aligned with the state register.
    function automatic bus_t bus_for_state(input state_t s, input logic [63:0] opnd);
        bus_t b;
        b     = '0;
        b.req = 1'b1;
        case (s)
            W_INTEN: begin
                b.wr   = 1'b1;
                b.addr = FACTO_BASE + OFF_INTR_EN;
                b.dout = 64'd1;
            end
            W_OPND: begin
                b.wr   = 1'b1;
                b.addr = FACTO_BASE + OFF_OPERAND;
                b.dout = opnd;
            end
            W_START: begin
                b.wr   = 1'b1;
                b.addr = FACTO_BASE + OFF_OPSTART;
                b.dout = 64'd1;
            end
            W_CLR1: begin
                b.wr   = 1'b1;
                b.addr = FACTO_BASE + OFF_OPCLEAR;
                b.dout = 64'd1;
            end
            W_CLR0: begin
                b.wr   = 1'b1;
                b.addr = FACTO_BASE + OFF_OPCLEAR;
                b.dout = 64'd0;
            end
            R_HI:             b.addr = FACTO_BASE + OFF_RESULT_H;
            R_LO:             b.addr = FACTO_BASE + OFF_RESULT_L;
            WAIT_INT, CAP_LO: b.addr = FACTO_BASE + OFF_OPDONE;
            REQ:              b.addr = 16'h0000;
            default:          b      = '0;   // IDLE, RELEASE: bus released
        endcase
        return b;
    endfunction

    // Next-state decode. Bus states advance only on a granted cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start)   state_nxt = REQ;
            REQ:      if (m_grant) state_nxt = W_INTEN;
            W_INTEN:  if (m_grant) state_nxt = W_OPND;
            W_OPND:   if (m_grant) state_nxt = W_START;
            W_START:  if (m_grant) state_nxt = WAIT_INT;
            WAIT_INT: begin
                // Interrupt wins over a timeout landing in the same cycle.
                if (interrupt)        state_nxt = R_HI;
                else if (timeout_hit) state_nxt = W_CLR1;
            end
            R_HI:     if (m_grant) state_nxt = R_LO;
            R_LO:     if (m_grant) state_nxt = CAP_LO;
            CAP_LO:                state_nxt = W_CLR1;
            W_CLR1:   if (m_grant) state_nxt = W_CLR0;
            W_CLR0:   if (m_grant) state_nxt = RELEASE;
            RELEASE:               state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bus_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            result    <= '0;
            wait_cnt  <= '0;
            operand_q <= '0;
        end else begin
            state <= state_nxt;
            bus_q <= bus_for_state(state_nxt, operand_q);
            busy  <= (state_nxt != IDLE) && (state_nxt != RELEASE);
            done  <= (state_nxt == RELEASE);

            case (state)
                IDLE: begin
                    if (start) begin
                        operand_q <= operand;
                        error     <= 1'b0;
                    end
                end
                W_START: wait_cnt <= '0;
                WAIT_INT: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    if (!interrupt && timeout_hit) error <= 1'b1;
                end
                // m_din here answers the R_HI read; it is taken on the
                // granted cycle that also completes the result_l read.
                R_LO:   if (m_grant) result[127:64] <= m_din;
                CAP_LO: result[63:0] <= m_din;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_facto_host.sv
// ---------------------------------------------------------------------------
// tb_facto_host
// Purpose : directed bench for facto_host with a behavioural factorial core
//           and bus slave. The DUT runs with TIMEOUT=100.
// ---------------------------------------------------------------------------
module tb_facto_host;
    import facto_host_pkg::*;

    localparam logic [15:0] BASE = 16'h7000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [63:0]   operand;
    logic          m_grant;
    logic [63:0]   m_din;
    logic          interrupt;
    logic          m_req;
    logic          m_wr;
    logic [15:0]   m_addr;
    logic [63:0]   m_dout;
    logic          busy;
    logic          done;
    logic          error;
    logic [127:0]  result;
    state_t        dbg_state;

    int tests = 0;
    int fails = 0;

    facto_host #(.FACTO_BASE(BASE), .TIMEOUT(16'd100)) dut (
        .clk(clk), .reset(reset), .start(start), .operand(operand),
        .m_grant(m_grant), .m_din(m_din), .interrupt(interrupt),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
        .busy(busy), .done(done), .error(error), .result(result),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- core / bus slave model ----------------
    logic [79:0]  wr_q[$];     // {addr, data} of each accepted write
    logic [79:0]  exp_q[$];
    logic [127:0] core_fact = 128'd0;
    int           int_delay = 20;   // <0: interrupt never raised
    int           int_cnt;
    int           done_cnt = 0;

    function automatic logic [127:0] fact(input logic [63:0] n);
        logic [127:0] f;
        f = 128'd1;
        for (int i = 2; i <= 34; i++)
            if (64'(i) <= n) f = f * 128'(i);
        return f;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            interrupt <= 1'b0;
            int_cnt   <= -1;
            m_din     <= '0;
        end else begin
            if (int_cnt > 0) int_cnt <= int_cnt - 1;
            else if (int_cnt == 0) begin
                interrupt <= 1'b1;
                int_cnt   <= -1;
            end
            if (m_req && m_grant && m_wr) begin
                wr_q.push_back({m_addr, m_dout});
                if (m_addr == BASE + 16'h20) core_fact <= fact(m_dout);
                if (m_addr == BASE + 16'h00 && m_dout == 64'd1 && int_delay >= 0)
                    int_cnt <= int_delay;
                if (m_addr == BASE + 16'h08 && m_dout == 64'd1) interrupt <= 1'b0;
            end else if (m_req && m_grant && !m_wr) begin
                if (m_addr == BASE + 16'h28) m_din <= core_fact[127:64];
                else if (m_addr == BASE + 16'h30) m_din <= core_fact[63:0];
            end
        end
    end

    // Bus must be fully quiet whenever m_req is low; also counts done pulses.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!reset && !m_req) begin
            tests++;
            if (m_wr !== 1'b0 || m_addr !== 16'h0 || m_dout !== 64'h0) begin
                fails++;
                $display("FAIL idle_bus got wr=%0b addr=%h dout=%h required all 0", m_wr, m_addr, m_dout);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [63:0] op);
        @(negedge clk);
        operand = op;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_state(input state_t s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (dbg_state == s) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic void expect_run(input logic [63:0] op);
        exp_q.delete();
        exp_q.push_back({16'h7018, 64'd1});
        exp_q.push_back({16'h7020, op});
        exp_q.push_back({16'h7000, 64'd1});
        exp_q.push_back({16'h7008, 64'd1});
        exp_q.push_back({16'h7008, 64'd0});
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; operand = '0; m_grant = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (m_req !== 1'b0 || m_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags got req=%0b wr=%0b busy=%0b done=%0b err=%0b required 0", m_req, m_wr, busy, done, error);
        end
        tests++;
        if (m_addr !== 16'h0 || m_dout !== 64'h0 || result !== 128'h0 || dbg_state !== IDLE) begin
            fails++;
            $display("FAIL reset_data got addr=%h dout=%h result=%h state=%0d required 0/IDLE", m_addr, m_dout, result, dbg_state);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int_delay = 20; m_grant = 1'b1;
        wr_q.delete(); done_cnt = 0;
        do_start(64'd5);
        tests++;
        if (busy !== 1'b1 || m_req !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy got busy=%0b req=%0b required 1/1", busy, m_req);
        end
        wait_done(400, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL basic_done got no done required done within 400 cycles"); end
        tests++;
        if (result !== 128'd120 || error !== 1'b0) begin
            fails++;
            $display("FAIL basic_result got %0d err=%0b required 120 err=0", result, error);
        end
        tests++;
        if (busy !== 1'b0 || m_req !== 1'b0) begin
            fails++;
            $display("FAIL basic_release got busy=%0b req=%0b required 0/0", busy, m_req);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || done_cnt != 1) begin
            fails++;
            $display("FAIL basic_done_pulse got done=%0b pulses=%0d required 0 and 1", done, done_cnt);
        end
        expect_run(64'd5);
        tests++;
        if (wr_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL basic_wr_count got %0d required %0d", wr_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                tests++;
                if (wr_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL basic_wr[%0d] got %h required %h", i, wr_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_values();
        bit ok;
        do_start(64'd20);
        wait_done(400, ok);
        tests++;
        if (!ok || result !== 128'd2432902008176640000 || error !== 1'b0) begin
            fails++;
            $display("FAIL fact20 got ok=%0b result=%0d err=%0b required 2432902008176640000 err=0", ok, result, error);
        end
        do_start(64'd25);
        wait_done(400, ok);
        tests++;
        if (!ok || result !== 128'd15511210043330985984000000) begin
            fails++;
            $display("FAIL fact25 got ok=%0b result=%0d required 15511210043330985984000000", ok, result);
        end
    endtask

    task automatic test_grant_stall();
        bit ok;
        m_grant = 1'b0;
        wr_q.delete(); done_cnt = 0;
        do_start(64'd6);
        repeat (7) @(negedge clk);
        tests++;
        if (dbg_state !== REQ || m_req !== 1'b1) begin
            fails++;
            $display("FAIL stall_req got state=%0d req=%0b required REQ/1", dbg_state, m_req);
        end
        m_grant = 1'b1;
        wait_state(W_OPND, 20, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL stall_reach_opnd got no W_OPND required within 20 cycles"); end
        m_grant = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (dbg_state !== W_OPND || m_dout !== 64'd6 || m_addr !== 16'h7020 || m_wr !== 1'b1) begin
            fails++;
            $display("FAIL stall_hold got state=%0d addr=%h dout=%0d required W_OPND 7020 6", dbg_state, m_addr, m_dout);
        end
        m_grant = 1'b1;
        wait_done(400, ok);
        tests++;
        if (!ok || result !== 128'd720) begin
            fails++;
            $display("FAIL stall_result got ok=%0b result=%0d required 720", ok, result);
        end
        expect_run(64'd6);
        tests++;
        if (wr_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL stall_wr_count got %0d required %0d", wr_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                tests++;
                if (wr_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL stall_wr[%0d] got %h required %h", i, wr_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        int_delay = -1;
        wr_q.delete();
        do_start(64'd9);
        wait_state(WAIT_INT, 20, ok);
        n = 0;
        while (dbg_state == WAIT_INT && n < 1000) begin
            n++;
            @(negedge clk);
        end
        tests++;
        if (!ok || n < 99 || n > 101) begin
            fails++;
            $display("FAIL timeout_cycles got %0d required about 100", n);
        end
        wait_done(50, ok);
        tests++;
        if (!ok || error !== 1'b1) begin
            fails++;
            $display("FAIL timeout_error got ok=%0b err=%0b required done with err=1", ok, error);
        end
        tests++;
        if (result !== 128'd720) begin
            fails++;
            $display("FAIL timeout_result got %0d required 720 (previous)", result);
        end
        expect_run(64'd9);
        tests++;
        if (wr_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL timeout_wr_count got %0d required %0d", wr_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                tests++;
                if (wr_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL timeout_wr[%0d] got %h required %h", i, wr_q[i], exp_q[i]);
                end
            end
        end
        int_delay = 20;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        wr_q.delete(); done_cnt = 0;
        do_start(64'd7);
        tests++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_err_clear got err=%0b busy=%0b required 0/1", error, busy);
        end
        repeat (3) @(negedge clk);
        operand = 64'd3;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_done(400, ok);
        tests++;
        if (!ok || result !== 128'd5040) begin
            fails++;
            $display("FAIL b2b_result got ok=%0b result=%0d required 5040", ok, result);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (done_cnt != 1 || busy !== 1'b0 || dbg_state !== IDLE) begin
            fails++;
            $display("FAIL b2b_single_run got pulses=%0d busy=%0b state=%0d required 1/0/IDLE", done_cnt, busy, dbg_state);
        end
        tests++;
        if (wr_q.size() != 5 || wr_q[1] !== {16'h7020, 64'd7}) begin
            fails++;
            $display("FAIL b2b_operand got count=%0d entry=%h required 5 and 7020/7", wr_q.size(), wr_q[1]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wr_q.delete();
        do_start(64'd4);
        wait_state(WAIT_INT, 20, ok);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (!ok || m_req !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE || result !== 128'd0) begin
            fails++;
            $display("FAIL midreset got ok=%0b req=%0b busy=%0b state=%0d result=%0d required 1/0/0/IDLE/0", ok, m_req, busy, dbg_state, result);
        end
        reset = 1'b0;
        tests++;
        if (wr_q.size() != 3) begin
            fails++;
            $display("FAIL midreset_no_clear got %0d writes required 3", wr_q.size());
        end
        do_start(64'd5);
        wait_done(400, ok);
        tests++;
        if (!ok || result !== 128'd120 || error !== 1'b0) begin
            fails++;
            $display("FAIL midreset_rerun got ok=%0b result=%0d err=%0b required 120 err=0", ok, result, error);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_values();
        test_grant_stall();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/facto_host.md
FACTO_HOST -- requirements
Module: facto_host

Interface
REQ-001 Parameter FACTO_BASE, default 16'h7000, base address of the factorial core register block.
REQ-002 Parameter TIMEOUT, default 16'd4095, maximum cycles spent in WAIT_INT before aborting.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 start  input  1  one-cycle request to compute operand!; ignored unless busy=0.
REQ-006 operand  input  64  value latched on accepted start.
REQ-007 m_grant  input  1  bus grant from arbiter.
REQ-008 m_din  input  64  read data returned by bus.
REQ-009 interrupt  input  1  level interrupt from factorial core.
REQ-010 m_req  output  1  bus request.
REQ-011 m_wr  output  1  1=write, 0=read; valid only while m_req=1 and m_grant=1.
REQ-012 m_addr  output  16  transaction address.
REQ-013 m_dout  output  64  write data.
REQ-014 busy  output  1  high from accepted start until done.
REQ-015 done  output  1  one-cycle pulse when result valid or on abort.
REQ-016 error  output  1  set with done on timeout; cleared on next accepted start.
REQ-017 result  output  128  {result_h, result_l}; held until next accepted start.

Function
REQ-018 Register offsets from FACTO_BASE: opstart +0x00, opclear +0x08, opdone +0x10, intrEn +0x18, operand +0x20, result_h +0x28, result_l +0x30.
REQ-019 States: IDLE, REQ, W_INTEN, W_OPND, W_START, WAIT_INT, R_HI, R_LO, CAP_LO, W_CLR1, W_CLR0, RELEASE.
REQ-020 IDLE: start=1 latches operand, clears error, sets busy, goes to REQ.
REQ-021 REQ: m_req=1, m_wr=0; advances to W_INTEN on first cycle with m_grant=1.
REQ-022 m_req stays 1 from REQ through W_CLR0 inclusive, including WAIT_INT; deasserted in RELEASE.
REQ-023 Each write state issues exactly one write cycle: W_INTEN data 1, W_OPND data operand, W_START data 1, W_CLR1 data 1 to opclear, W_CLR0 data 0 to opclear.
REQ-024 If m_grant drops in any bus state, FSM holds state and outputs until m_grant returns; no transaction counted.
REQ-025 WAIT_INT: idle bus (m_wr=0, m_addr=FACTO_BASE+0x10); exits to R_HI when interrupt=1; 16-bit counter increments each cycle.
REQ-026 Counter reaching TIMEOUT: error=1, go to W_CLR1 (core cleared), result unchanged.
REQ-027 Read latency one cycle: address issued in R_HI, m_din captured to result[127:64] in R_LO while R_LO issues result_l address; m_din captured to result[63:0] in CAP_LO.
REQ-028 RELEASE: m_req=0, done=1 for one cycle, busy=0, return to IDLE.
REQ-029 start while busy=1 ignored; operand=0 handled by core (result 1), no special case.
REQ-030 Outputs registered; m_wr=0, m_addr=0, m_dout=0 whenever m_req=0.

Reset
REQ-031 reset=1 forces IDLE; m_req, m_wr, busy, done, error=0; m_addr, m_dout=0; result=0; counter=0.
REQ-032 Reset mid-transaction abandons it immediately; no opclear issued; bus released next cycle.

Structure
REQ-033 Shared package holds state encoding and register offset constants; FACTO_BASE stays a module parameter.
REQ-034 Single module, no sub-modules; timeout counter inline.

Verification
REQ-035 operand=5, grant immediate, interrupt 20 cycles after opstart write -> writes 1,5,1 to 0x7018,0x7020,0x7000; result=128'd120; done one pulse; opclear writes 1 then 0.
REQ-036 operand=20 -> result=128'd2432902008176640000, error=0.
REQ-037 m_grant delayed 7 cycles and dropped 2 cycles during W_OPND -> no duplicate or skipped writes; result correct.
REQ-038 interrupt never asserted, TIMEOUT=100 -> done and error at cycle ~100 of WAIT_INT, opclear issued, result retains previous value.
REQ-039 reset asserted in WAIT_INT -> next cycle m_req=0, busy=0; new start then completes normally.
REQ-040 start pulsed while busy -> ignored; operand latched at first start used.
